// File: rtl/alu_wb_queue.sv
// Small circular result buffer between the ALU and the writeback/commit port.
// Head is driven from registered storage only; ready depends on occupancy alone.
module alu_wb_queue #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [XLEN-1:0]            alu_result_i,
    input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
    input  logic                       alu_branch_res_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [XLEN-1:0]            wb_result_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic                       wb_branch_res_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     branch_res;
    } entry_t;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           entries [DEPTH];

    // Modulo-DEPTH increment so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign alu_ready_o = (count_q != CNT_W'(DEPTH));
    assign wb_valid_o  = (count_q != '0);
    assign count_o     = count_q;

    assign push = alu_valid_i & alu_ready_o & ~flush_i;
    assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

    assign wr_entry = '{result: alu_result_i, trans_id: alu_trans_id_i, branch_res: alu_branch_res_i};

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            entry_t entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = wr_entry;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    assign wb_result_o     = entries[rd_ptr_q].result;
    assign wb_trans_id_o   = entries[rd_ptr_q].trans_id;
    assign wb_branch_res_o = entries[rd_ptr_q].branch_res;

endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed bench for alu_wb_queue: vector table for the basic push/pop/back-pressure
// sequence, then hand-written streaming, flush and asynchronous-reset sequences.
module tb_alu_wb_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [63:0] alu_result;
    logic [2:0]  alu_trans_id;
    logic        alu_branch_res;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_result;
    logic [2:0]  wb_trans_id;
    logic        wb_branch_res;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    logic allow_proto_err = 1'b0;

    alu_wb_queue #(.XLEN(64), .DEPTH(2), .TRANS_ID_BITS(3)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .alu_valid_i      (alu_valid),
        .alu_ready_o      (alu_ready),
        .alu_result_i     (alu_result),
        .alu_trans_id_i   (alu_trans_id),
        .alu_branch_res_i (alu_branch_res),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_result_o      (wb_result),
        .wb_trans_id_o    (wb_trans_id),
        .wb_branch_res_o  (wb_branch_res),
        .count_o          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [63:0] res;
        logic [2:0]  tid;
        logic        br;
        logic        rdy;
        logic        fl;
        logic        proto_ok;
        logic        e_valid;
        logic        e_ardy;
        logic [1:0]  e_cnt;
        logic        cd;
        logic [63:0] e_res;
        logic [2:0]  e_tid;
        logic        e_br;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Producer-side protocol check happens just before each edge.
    task automatic step();
        n_checks++;
        if (alu_valid && !alu_ready && !allow_proto_err) begin
            n_fail++;
            $display("FAIL protocol: alu_valid=1 while alu_ready=0 at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [2:0] tid,
                         input logic br, input logic rdy, input logic fl);
        alu_valid      = v;
        alu_result     = res;
        alu_trans_id   = tid;
        alu_branch_res = br;
        wb_ready       = rdy;
        flush          = fl;
    endtask

    initial begin
        //            name          v  res       tid br rdy fl pok  eV eRdy eCnt cd eRes     eTid eBr
        vecs[0] = '{"idle",        0, 64'h0,    0, 0, 0, 0, 0,   0, 1, 2'd0, 1, 64'h0,    0, 0};
        vecs[1] = '{"push1234",    1, 64'h1234, 5, 1, 0, 0, 0,   1, 1, 2'd1, 1, 64'h1234, 5, 1};
        vecs[2] = '{"pop1234",     0, 64'h0,    0, 0, 1, 0, 0,   0, 1, 2'd0, 1, 64'h0,    0, 0};
        vecs[3] = '{"pushA",       1, 64'hA,    1, 0, 0, 0, 0,   1, 1, 2'd1, 1, 64'hA,    1, 0};
        vecs[4] = '{"pushB_full",  1, 64'hB,    2, 1, 0, 0, 0,   1, 0, 2'd2, 1, 64'hA,    1, 0};
        vecs[5] = '{"ignored_EE",  1, 64'hEE,   7, 1, 0, 0, 1,   1, 0, 2'd2, 1, 64'hA,    1, 0};
        vecs[6] = '{"popA_nopush", 1, 64'hEF,   6, 0, 1, 0, 1,   1, 1, 2'd1, 1, 64'hB,    2, 1};
        vecs[7] = '{"popB",        0, 64'h0,    0, 0, 1, 0, 0,   0, 1, 2'd0, 0, 64'h0,    0, 0};

        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;

        chk("reset_valid", 64'(wb_valid), 64'h0);
        chk("reset_ready", 64'(alu_ready), 64'h1);
        chk("reset_count", 64'(count), 64'h0);
        chk("reset_result", wb_result, 64'h0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].res, vecs[i].tid, vecs[i].br, vecs[i].rdy, vecs[i].fl);
            allow_proto_err = vecs[i].proto_ok;
            step();
            allow_proto_err = 1'b0;
            chk({vecs[i].name, ".valid"}, 64'(wb_valid), 64'(vecs[i].e_valid));
            chk({vecs[i].name, ".ready"}, 64'(alu_ready), 64'(vecs[i].e_ardy));
            chk({vecs[i].name, ".count"}, 64'(count), 64'(vecs[i].e_cnt));
            if (vecs[i].cd) begin
                chk({vecs[i].name, ".result"}, wb_result, vecs[i].e_res);
                chk({vecs[i].name, ".tid"}, 64'(wb_trans_id), 64'(vecs[i].e_tid));
                chk({vecs[i].name, ".br"}, 64'(wb_branch_res), 64'(vecs[i].e_br));
            end
        end

        // Streaming: each value is visible the cycle after its push, while the previous pops.
        for (int i = 0; i < 16; i++) begin
            drive(1, 64'(i), 3'(i), 1'(i), 1, 0);
            step();
            chk($sformatf("stream%0d.valid", i), 64'(wb_valid), 64'h1);
            chk($sformatf("stream%0d.result", i), wb_result, 64'(i));
            chk($sformatf("stream%0d.tid", i), 64'(wb_trans_id), 64'(i % 8));
            chk($sformatf("stream%0d.count", i), 64'(count), 64'h1);
        end
        drive(0, 0, 0, 0, 1, 0);
        step();
        chk("stream_drain.valid", 64'(wb_valid), 64'h0);
        chk("stream_drain.count", 64'(count), 64'h0);

        // Flush with a full queue plus an offered 0xC.
        drive(1, 64'h11, 1, 0, 0, 0); step();
        drive(1, 64'h22, 2, 0, 0, 0); step();
        chk("flush_fill.count", 64'(count), 64'h2);
        drive(1, 64'hC, 3, 0, 1, 1);
        allow_proto_err = 1'b1;
        step();
        allow_proto_err = 1'b0;
        chk("flush_full.count", 64'(count), 64'h0);
        chk("flush_full.valid", 64'(wb_valid), 64'h0);
        chk("flush_full.ready", 64'(alu_ready), 64'h1);

        // Flush with one entry: the push of 0xC is accepted by ready but must be dropped.
        drive(1, 64'h33, 4, 0, 0, 0); step();
        drive(1, 64'hC, 3, 1, 1, 1); step();
        chk("flush_one.count", 64'(count), 64'h0);
        chk("flush_one.valid", 64'(wb_valid), 64'h0);
        drive(1, 64'hD, 6, 1, 0, 0); step();
        chk("after_flush.valid", 64'(wb_valid), 64'h1);
        chk("after_flush.result", wb_result, 64'hD);
        chk("after_flush.tid", 64'(wb_trans_id), 64'h6);
        drive(0, 0, 0, 0, 1, 0); step();
        chk("after_flush_pop.valid", 64'(wb_valid), 64'h0);
        chk("after_flush_pop.count", 64'(count), 64'h0);

        // Asynchronous reset while full, between clock edges.
        drive(1, 64'h44, 1, 1, 0, 0); step();
        drive(1, 64'h55, 2, 1, 0, 0); step();
        chk("pre_areset.count", 64'(count), 64'h2);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("areset.valid", 64'(wb_valid), 64'h0);
        chk("areset.count", 64'(count), 64'h0);
        chk("areset.ready", 64'(alu_ready), 64'h1);
        chk("areset.result", wb_result, 64'h0);
        #1;
        rst = 1'b0;
        #1;
        drive(1, 64'h66, 3, 0, 0, 0); step();
        chk("post_areset.valid", 64'(wb_valid), 64'h1);
        chk("post_areset.result", wb_result, 64'h66);
        chk("post_areset.count", 64'(count), 64'h1);
        drive(0, 0, 0, 0, 1, 0); step();
        chk("post_areset_pop.valid", 64'(wb_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
